// File: rtl/ps2_key_serializer_pkg.sv
// Shared types and constants for the PS/2 key serializer.
// Frame state encoding, scan-code prefixes and the small helpers used to
// build a byte sequence from a key event.
package ps2_key_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  // PS/2 parity bit: makes the count of ones across data+parity odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bytes emitted for one event: optional E0, optional F0, then the code
  function automatic logic [1:0] seq_len(input logic ext, input logic pressed);
    return 2'd1 + {1'b0, ext} + {1'b0, ~pressed};
  endfunction

endpackage

// File: rtl/ps2_key_serializer_byte_fifo.sv
// Purpose: small synchronous byte FIFO with free-slot count for all-or-nothing admission.
// Latency: a written byte is visible on rd_dat/rd_vld the cycle after the write.
// Backpressure: writes into a full FIFO are ignored unless a read happens in the same cycle.
module ps2_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             rd_vld,
  output logic [CW-1:0]    free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd  = rd_rdy && (count != '0);
  assign do_wr  = wr_vld && ((count != CW'(DEPTH)) || do_rd);
  assign rd_dat = mem[rd_ptr];
  assign rd_vld = (count != '0);
  assign free   = CW'(DEPTH) - count;

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// Purpose: turns toggle-strobed key events into E0/F0/code byte sequences sent as PS/2 frames.
// Latency: first data change 2-4 cycles after the toggle; frame = 11*BIT + GAP_BITS*BIT cycles.
// Backpressure: none upstream; events that do not fit the byte FIFO are dropped with overflow.
module ps2_key_serializer
  import ps2_key_serializer_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PS2_HZ     = 12_500,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);

  localparam int BIT     = CLK_HZ / PS2_HZ;
  localparam int HALF    = BIT / 2;
  localparam int GAP_CYC = GAP_BITS * BIT;
  localparam int TMAX    = (GAP_CYC > HALF) ? GAP_CYC : HALF;
  localparam int CNT_W   = $clog2(TMAX + 1);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  // Enqueuer state
  logic       last_tog;
  logic       enq_act;
  logic       enq_ext;
  logic       enq_brk;
  logic [7:0] enq_code;
  logic       key_pending;
  logic [1:0] need_n;

  // FIFO interface
  logic          wr_vld;
  logic [7:0]    wr_dat;
  logic          rd_rdy;
  logic [7:0]    rd_dat;
  logic          rd_vld;
  logic [CW-1:0] fifo_free;

  // Frame engine state
  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [9:0]       shreg;

  assign key_pending = ps2_key[10] ^ last_tog;
  assign need_n      = seq_len(ps2_key[8], ps2_key[9]);
  assign wr_vld      = enq_act;
  assign rd_rdy      = (state == IDLE) && rd_vld;
  assign busy        = rd_vld || (state != IDLE) || enq_act;

  // Prefixes go out first; each flag clears as its byte is written
  always_comb begin
    wr_dat = enq_code;
    if (enq_ext)      wr_dat = PS2_EXT_PREFIX;
    else if (enq_brk) wr_dat = PS2_BREAK_PREFIX;
  end

  ps2_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .wr_vld  (wr_vld),
    .wr_dat  (wr_dat),
    .rd_rdy  (rd_rdy),
    .rd_dat  (rd_dat),
    .rd_vld  (rd_vld),
    .free    (fifo_free)
  );

  // Event detect and all-or-nothing admission; a busy enqueuer ignores toggles until done
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_tog <= ps2_key[10];
      enq_act  <= 1'b0;
      enq_ext  <= 1'b0;
      enq_brk  <= 1'b0;
      enq_code <= 8'h00;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (enq_act) begin
        if (enq_ext)      enq_ext <= 1'b0;
        else if (enq_brk) enq_brk <= 1'b0;
        else              enq_act <= 1'b0;
      end else if (key_pending) begin
        last_tog <= ps2_key[10];
        enq_code <= ps2_key[7:0];
        if (fifo_free >= CW'(need_n)) begin
          enq_act <= 1'b1;
          enq_ext <= ps2_key[8];
          enq_brk <= ~ps2_key[9];
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Frame engine: data changes only on entry to BIT_HI, clock falls HALF cycles later
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      shreg    <= 10'd0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_vld) begin
            shreg    <= {1'b1, odd_parity(rd_dat), rd_dat};
            ps2_data <= 1'b0;
            ps2_clk  <= 1'b1;
            bit_idx  <= 4'd0;
            cnt      <= '0;
            state    <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            ps2_clk <= 1'b0;
            state   <= BIT_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BIT_LO: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              ps2_data <= 1'b1;
              state    <= GAP;
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              ps2_data <= shreg[0];
              shreg    <= {1'b0, shreg[9:1]};
              state    <= BIT_HI;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Randomized bench for ps2_key_serializer with a frame-decoding receiver as monitor.
// Expected bytes are queued at stimulus time from the event-to-sequence rules.
// Runs with a scaled bit period so every scenario fits a short simulation.
module tb_ps2_key_serializer;

  localparam int CLK_HZ   = 1600;
  localparam int PS2_HZ   = 100;
  localparam int BIT      = CLK_HZ / PS2_HZ;
  localparam int HALF     = BIT / 2;
  localparam int GAP_BITS = 2;
  localparam int DEPTH    = 4;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = 11'd0;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  ps2_key_serializer #(
    .CLK_HZ     (CLK_HZ),
    .PS2_HZ     (PS2_HZ),
    .GAP_BITS   (GAP_BITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];
  int frames = 0;
  int falls = 0;
  int ovf_cycles = 0;

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference rule: optional E0 for extended, optional F0 for release, then the code
  task automatic push_expected(input logic pressed, input logic ext, input logic [7:0] code);
    if (ext) exp_q.push_back(8'hE0);
    if (!pressed) exp_q.push_back(8'hF0);
    exp_q.push_back(code);
  endtask

  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    @(posedge clk_sys);
    #1;
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ps2_data;
      1:       return ps2_clk;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input logic val,
                          input int max_cyc, output int t);
    bit hit;
    hit = 1'b0;
    t = 0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk_sys);
      if (sig(sel) == val) begin
        hit = 1'b1;
        t = cyc;
      end
    end
    if (!hit) chk({name, "_timeout"}, 1'b0, max_cyc, 0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    repeat (2) @(posedge clk_sys);
    wait_for(name, 2, 1'b0, 2000, t);
  endtask

  // Receiver: decodes frames at clock falls and checks line timing
  int         bit_n = 0;
  int         last_chg = 0;
  int         last_fall = 0;
  int         last_stop = 0;
  bit         have_stop = 1'b0;
  logic       prev_clk = 1'b1;
  logic       prev_data = 1'b1;
  logic [10:0] frame = '0;

  always @(negedge clk_sys) begin
    if (reset) begin
      bit_n     = 0;
      have_stop = 1'b0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
      last_chg  = cyc;
    end else begin
      if (ps2_data != prev_data) last_chg = cyc;
      if (prev_clk && !ps2_clk) begin
        falls++;
        chk("data_setup", (cyc - last_chg) >= HALF, cyc - last_chg, HALF);
        if (bit_n == 0) begin
          if (have_stop)
            chk("inter_frame_gap", (cyc - last_stop) >= BIT * (1 + GAP_BITS),
                cyc - last_stop, BIT * (1 + GAP_BITS));
        end else begin
          chk("fall_spacing", (cyc - last_fall) == BIT, cyc - last_fall, BIT);
        end
        frame[bit_n] = ps2_data;
        last_fall = cyc;
        bit_n++;
        if (bit_n == 11) begin
          logic [7:0] got;
          logic [7:0] want;
          got = frame[8:1];
          chk("start_bit", frame[0] == 1'b0, int'(frame[0]), 0);
          chk("stop_bit", frame[10] == 1'b1, int'(frame[10]), 1);
          chk("odd_parity", (^frame[9:1]) == 1'b1, int'(frame[9]), int'(~^got));
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1'b0, int'(got), -1);
          end else begin
            want = exp_q.pop_front();
            chk("frame_byte", got == want, int'(got), int'(want));
          end
          frames++;
          last_stop = cyc;
          have_stop = 1'b1;
          bit_n = 0;
        end
      end
      if (overflow) ovf_cycles++;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, f0, o0;
    logic pr, ex;
    logic [7:0] cd;

    // Reset state
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("reset_clk", ps2_clk == 1'b1, int'(ps2_clk), 1);
    chk("reset_data", ps2_data == 1'b1, int'(ps2_data), 1);
    chk("reset_busy", busy == 1'b0, int'(busy), 0);
    chk("reset_overflow", overflow == 1'b0, int'(overflow), 0);
    @(posedge clk_sys);
    #1 reset = 1'b0;

    // Single make code: first fall HALF after start bit, busy lasts 13 bit periods
    send(1'b1, 1'b0, 8'h1C);
    push_expected(1'b1, 1'b0, 8'h1C);
    wait_for("start_low", 0, 1'b0, 100, t0);
    wait_for("first_fall", 1, 1'b0, 100, t1);
    chk("first_fall_delay", (t1 - t0) == HALF, t1 - t0, HALF);
    wait_for("busy_drop", 2, 1'b0, 2000, t2);
    chk("frame_length", (t2 - t0) == 13 * BIT, t2 - t0, 13 * BIT);
    chk("t1_frames", frames == 1, frames, 1);

    // Extended release: E0, F0, 74
    send(1'b0, 1'b1, 8'h74);
    push_expected(1'b0, 1'b1, 8'h74);
    wait_idle("t2_idle");
    chk("t2_frames", frames == 4, frames, 4);

    // Three back-to-back extended releases: only the first fits a depth-4 FIFO
    o0 = ovf_cycles;
    send(1'b0, 1'b1, 8'h5A);
    push_expected(1'b0, 1'b1, 8'h5A);
    repeat (4) @(posedge clk_sys);
    send(1'b0, 1'b1, 8'h6C);
    repeat (4) @(posedge clk_sys);
    send(1'b0, 1'b1, 8'h7D);
    wait_idle("t3_idle");
    chk("overflow_pulses", (ovf_cycles - o0) == 2, ovf_cycles - o0, 2);
    chk("t3_queue_drained", exp_q.size() == 0, exp_q.size(), 0);

    // Reset in the middle of a frame
    send(1'b0, 1'b1, 8'h11);
    push_expected(1'b0, 1'b1, 8'h11);
    wait_for("t4_start", 0, 1'b0, 100, t0);
    repeat (60) @(posedge clk_sys);
    #1 reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("midreset_clk", ps2_clk == 1'b1, int'(ps2_clk), 1);
    chk("midreset_data", ps2_data == 1'b1, int'(ps2_data), 1);
    chk("midreset_busy", busy == 1'b0, int'(busy), 0);
    exp_q.delete();
    @(posedge clk_sys);
    #1 reset = 1'b0;
    f0 = falls;
    repeat (300) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("no_falls_after_reset", falls == f0, falls - f0, 0);
    chk("idle_after_reset", busy == 1'b0, int'(busy), 0);

    // Reset with toggle high: no event until the toggle actually changes
    @(posedge clk_sys);
    #1 reset = 1'b1;
    ps2_key = {1'b1, ps2_key[9:0]};
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    f0 = falls;
    repeat (300) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("no_spurious_frame", falls == f0, falls - f0, 0);
    chk("no_spurious_busy", busy == 1'b0, int'(busy), 0);
    t0 = frames;
    send(1'b1, 1'b1, 8'h6B);
    push_expected(1'b1, 1'b1, 8'h6B);
    wait_idle("t6_idle");
    chk("t6_one_sequence", (frames - t0) == 2, frames - t0, 2);

    // Random events, each allowed to drain before the next
    for (int k = 0; k < 20; k++) begin
      pr = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      cd = 8'($urandom_range(0, 255));
      send(pr, ex, cd);
      push_expected(pr, ex, cd);
      wait_idle("rand_idle");
    end

    repeat (20) @(posedge clk_sys);
    chk("final_queue_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
